// File: rtl/loader_pkg.sv
// loader_pkg: shared constants, header field positions, FSM state
// encoding and the decoded-header record for instr_rom_loader.
package loader_pkg;

    localparam logic [7:0] LOAD_MAGIC    = 8'hA5;
    localparam logic [7:0] RELEASE_MAGIC = 8'h5A;

    // Header word layout: [31:24] magic, [23:8] count, [3:0] node id.
    // Bits [7:4] are reserved and ignored.
    localparam int HDR_MAGIC_HI = 31;
    localparam int HDR_MAGIC_LO = 24;
    localparam int HDR_CNT_HI   = 23;
    localparam int HDR_CNT_LO   = 8;
    localparam int HDR_NODE_HI  = 3;
    localparam int HDR_NODE_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic        is_load;
        logic        is_release;
        logic [3:0]  node;
        logic [15:0] count;
        logic        valid;
    } hdr_t;

endpackage

// File: rtl/loader_hdr_decode.sv
// loader_hdr_decode: purely combinational header classification.
// Takes the header fields already sliced out of the host word and
// reports the opcode, the target node, the word count and whether the
// header is legal for this array size / memory depth.
module loader_hdr_decode
    import loader_pkg::*;
#(
    parameter int NODE_COUNT = 9,
    parameter int ROM_SIZE   = 128
)(
    input  logic [7:0]  i_magic,
    input  logic [15:0] i_count,
    input  logic [3:0]  i_node,
    output hdr_t        o_hdr
);

    logic w_node_ok;
    logic w_cnt_ok;

    assign w_node_ok = (32'(i_node) < NODE_COUNT);
    // A load must carry at least one word and must fit in the memory,
    // which is what keeps the write address from ever wrapping.
    assign w_cnt_ok  = (i_count != 16'd0) && (32'(i_count) <= ROM_SIZE);

    // Classify the header; release needs only a legal node id.
    always_comb begin
        o_hdr            = '0;
        o_hdr.is_load    = (i_magic == LOAD_MAGIC);
        o_hdr.is_release = (i_magic == RELEASE_MAGIC);
        o_hdr.node       = i_node;
        o_hdr.count      = i_count;
        o_hdr.valid      = w_node_ok &&
                           (o_hdr.is_release || (o_hdr.is_load && w_cnt_ok));
    end

endmodule

// File: rtl/instr_rom_loader.sv
// instr_rom_loader: streams instruction words from the host link into
// the per-node instruction memories and holds each core in reset until
// its program is in place.
// Optional feature macro: LOADER_CHECKSUM_EN -- adds a trailing XOR
// checksum word per LOAD frame and a CHECK state that verifies it.
module instr_rom_loader
    import loader_pkg::*;
#(
    parameter int NODE_COUNT = 9,
    parameter int ROM_SIZE   = 128,
    parameter int ADDR_W     = $clog2(ROM_SIZE)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [31:0]           s_data,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [3:0]            mem_node,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [NODE_COUNT-1:0] core_hold,
    output logic                  busy,
    output logic                  err
);

    state_t                r_state;
    state_t                w_next;

    logic [3:0]            r_node;
    logic [15:0]           r_count;
    logic [ADDR_W-1:0]     r_addr;

    logic                  r_we;
    logic [3:0]            r_wnode;
    logic [ADDR_W-1:0]     r_waddr;
    logic [31:0]           r_wdata;

    logic [NODE_COUNT-1:0] r_hold;
    logic                  r_err;

    hdr_t                  w_hdr;
    logic                  w_hdr_acc;
    logic                  w_hdr_load;
    logic                  w_hdr_rel;
    logic                  w_hdr_bad;
    logic                  w_data_acc;
    logic                  w_last;
    logic                  w_ck_fail;

    loader_hdr_decode #(
        .NODE_COUNT (NODE_COUNT),
        .ROM_SIZE   (ROM_SIZE)
    ) u_hdr_decode (
        .i_magic (s_data[HDR_MAGIC_HI:HDR_MAGIC_LO]),
        .i_count (s_data[HDR_CNT_HI:HDR_CNT_LO]),
        .i_node  (s_data[HDR_NODE_HI:HDR_NODE_LO]),
        .o_hdr   (w_hdr)
    );

    // Ready never looks at s_valid: only the one-cycle DONE state stalls.
    assign s_ready    = (r_state != ST_DONE);
    assign busy       = (r_state != ST_IDLE);

    assign w_hdr_acc  = (r_state == ST_IDLE) && s_valid;
    assign w_hdr_load = w_hdr_acc && w_hdr.valid && w_hdr.is_load;
    assign w_hdr_rel  = w_hdr_acc && w_hdr.valid && w_hdr.is_release;
    assign w_hdr_bad  = w_hdr_acc && !w_hdr.valid;
    assign w_data_acc = (r_state == ST_LOAD) && s_valid;
    assign w_last     = (16'(r_addr) == (r_count - 16'd1));

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_xor;

    // Running XOR of the data words; restarts on every LOAD header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_xor <= '0;
        else if (w_hdr_load) r_xor <= '0;
        else if (w_data_acc) r_xor <= r_xor ^ s_data;
    end

    assign w_ck_fail = (r_state == ST_CHECK) && s_valid && (s_data != r_xor);
`else
    assign w_ck_fail = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_hdr_load) w_next = ST_LOAD;
            end
            ST_LOAD: begin
`ifdef LOADER_CHECKSUM_EN
                if (s_valid && w_last) w_next = ST_CHECK;
`else
                if (s_valid && w_last) w_next = ST_DONE;
`endif
            end
            ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (s_valid) w_next = w_ck_fail ? ST_IDLE : ST_DONE;
`else
                w_next = ST_IDLE;
`endif
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Frame context: latch target and length on a LOAD header, then
    // step the write address per data word (held at the last slot).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_node  <= '0;
            r_count <= '0;
            r_addr  <= '0;
        end else if (w_hdr_load) begin
            r_node  <= w_hdr.node;
            r_count <= w_hdr.count;
            r_addr  <= '0;
        end else if (w_data_acc && !w_last) begin
            r_addr  <= r_addr + ADDR_W'(1);
        end
    end

    // Registered memory write port: one strobe per accepted data word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_wnode <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_data_acc;
            if (w_data_acc) begin
                r_wnode <= r_node;
                r_waddr <= r_addr;
                r_wdata <= s_data;
            end
        end
    end

    // Per-core hold: set by LOAD, cleared by RELEASE or leaving DONE.
    // A failed checksum never reaches DONE, so that core stays held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '1;
        end else begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                if (w_hdr_load && (w_hdr.node == 4'(i)))
                    r_hold[i] <= 1'b1;
                else if (w_hdr_rel && (w_hdr.node == 4'(i)))
                    r_hold[i] <= 1'b0;
                else if ((r_state == ST_DONE) && (r_node == 4'(i)))
                    r_hold[i] <= 1'b0;
            end
        end
    end

    // Sticky error: set by a bad header or checksum, cleared by a good header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_err <= 1'b0;
        else if (w_hdr_bad || w_ck_fail) r_err <= 1'b1;
        else if (w_hdr_acc)              r_err <= 1'b0;
    end

    assign mem_we    = r_we;
    assign mem_node  = r_wnode;
    assign mem_addr  = r_waddr;
    assign mem_wdata = r_wdata;
    assign core_hold = r_hold;
    assign err       = r_err;

endmodule

// File: tb/tb_instr_rom_loader.sv
// Directed bench for instr_rom_loader; follows LOADER_CHECKSUM_EN if defined.
module tb_instr_rom_loader;

    localparam int NODE_COUNT = 9;
    localparam int ROM_SIZE   = 128;
    localparam int ADDR_W     = 7;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  s_valid = 1'b0;
    logic [31:0]           s_data = '0;
    logic                  s_ready;
    logic                  mem_we;
    logic [3:0]            mem_node;
    logic [ADDR_W-1:0]     mem_addr;
    logic [31:0]           mem_wdata;
    logic [NODE_COUNT-1:0] core_hold;
    logic                  busy;
    logic                  err;

    int total = 0;
    int bad   = 0;
    logic [NODE_COUNT-1:0] exp_hold;

    logic        cap_en = 1'b0;
    logic [3:0]  cap_node[$];
    logic [6:0]  cap_addr[$];
    logic [31:0] cap_data[$];

    instr_rom_loader #(
        .NODE_COUNT (NODE_COUNT),
        .ROM_SIZE   (ROM_SIZE),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_node  (mem_node),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_hold (core_hold),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cap_en && mem_we) begin
            cap_node.push_back(mem_node);
            cap_addr.push_back(mem_addr);
            cap_data.push_back(mem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (core_hold !== 9'h1FF) begin bad++; $display("FAIL reset_hold: got %h want 1ff", core_hold); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", s_ready); end
        total++; if ({mem_we, mem_node, mem_addr, mem_wdata} !== 44'd0) begin bad++; $display("FAIL reset_wport: got we=%b n=%h a=%h d=%h want zeros", mem_we, mem_node, mem_addr, mem_wdata); end
        total++; if ({busy, err} !== 2'b00) begin bad++; $display("FAIL reset_busy_err: got %b%b want 00", busy, err); end
        rst_n = 1'b1;
        step();
        total++; if ({s_ready, busy, mem_we} !== 3'b100) begin bad++; $display("FAIL post_reset_idle: got %b want 100", {s_ready, busy, mem_we}); end
        exp_hold = '1;
    endtask

    task automatic test_load_basic();
        logic [31:0] w [3];
        logic [31:0] cs;
        w[0] = 32'h00500293; w[1] = 32'h005282b3; w[2] = 32'h00000063;
        cs = 32'h0;
        s_valid = 1'b1; s_data = 32'hA5000301;
        step();
        total++; if ({busy, err, core_hold} !== {2'b10, exp_hold}) begin bad++; $display("FAIL load_hdr: got busy=%b err=%b hold=%h want 1 0 %h", busy, err, core_hold, exp_hold); end
        for (int i = 0; i < 3; i++) begin
            s_data = w[i];
            step();
            cs = cs ^ w[i];
            total++; if ({mem_we, mem_node, mem_addr, mem_wdata} !== {1'b1, 4'd1, 7'(i), w[i]}) begin bad++; $display("FAIL load_write%0d: got we=%b n=%h a=%h d=%h want 1 1 %h %h", i, mem_we, mem_node, mem_addr, mem_wdata, i, w[i]); end
        end
`ifdef LOADER_CHECKSUM_EN
        s_data = cs;
        step();
        total++; if ({mem_we, err} !== 2'b00) begin bad++; $display("FAIL load_check: got we=%b err=%b want 0 0", mem_we, err); end
`endif
        s_valid = 1'b0;
        total++; if ({s_ready, core_hold[1]} !== 2'b01) begin bad++; $display("FAIL load_done: got ready=%b hold1=%b want 0 1", s_ready, core_hold[1]); end
        step();
        exp_hold[1] = 1'b0;
        total++; if (core_hold !== exp_hold) begin bad++; $display("FAIL load_release_hold: got %h want %h", core_hold, exp_hold); end
        total++; if ({busy, s_ready, mem_we} !== 3'b010) begin bad++; $display("FAIL load_idle: got %b want 010", {busy, s_ready, mem_we}); end
    endtask

    task automatic test_release();
        s_valid = 1'b1; s_data = 32'h5A000004;
        step();
        s_valid = 1'b0;
        exp_hold[4] = 1'b0;
        total++; if (core_hold !== exp_hold) begin bad++; $display("FAIL release_hold: got %h want %h", core_hold, exp_hold); end
        total++; if ({mem_we, busy, err} !== 3'b000) begin bad++; $display("FAIL release_side: got %b want 000", {mem_we, busy, err}); end
    endtask

    task automatic test_bad_headers();
        logic [31:0] bw [5];
        bw[0] = 32'h33000301;   // bad magic
        bw[1] = 32'hA5000309;   // node 9
        bw[2] = 32'hA5000001;   // N = 0
        bw[3] = 32'hA5008101;   // N = 129
        bw[4] = 32'h5A000009;   // release of node 9
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = bw[i];
            step();
            s_valid = 1'b0;
            total++; if ({err, busy, mem_we} !== 3'b100) begin bad++; $display("FAIL bad_hdr%0d: got err/busy/we=%b want 100", i, {err, busy, mem_we}); end
            total++; if (core_hold !== exp_hold) begin bad++; $display("FAIL bad_hdr%0d_hold: got %h want %h", i, core_hold, exp_hold); end
            step();
            total++; if ({err, busy} !== 2'b10) begin bad++; $display("FAIL bad_hdr%0d_stay: got %b want 10", i, {err, busy}); end
            s_valid = 1'b1; s_data = 32'h5A000004;
            step();
            s_valid = 1'b0;
            total++; if (err !== 1'b0) begin bad++; $display("FAIL bad_hdr%0d_clear: got %b want 0", i, err); end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        s_valid = 1'b1; s_data = 32'hA5000201;
        step();
        exp_hold[1] = 1'b1;
        s_data = 32'h11111111; step();
        s_data = 32'h22222222; step();
        s_data = 32'h33333330; step();
        s_valid = 1'b0;
        total++; if ({err, busy, s_ready} !== 3'b101) begin bad++; $display("FAIL bad_cksum: got err/busy/ready=%b want 101", {err, busy, s_ready}); end
        step();
        total++; if (core_hold !== exp_hold) begin bad++; $display("FAIL bad_cksum_hold: got %h want %h", core_hold, exp_hold); end
    endtask
`else
    task automatic test_trailing_word();
        s_valid = 1'b1; s_data = 32'hA5000102;
        step();
        exp_hold[2] = 1'b1;
        s_data = 32'hCAFEF00D;
        step();
        total++; if ({mem_we, mem_node, mem_addr, mem_wdata} !== {1'b1, 4'd2, 7'd0, 32'hCAFEF00D}) begin bad++; $display("FAIL trail_write: got we=%b n=%h a=%h d=%h", mem_we, mem_node, mem_addr, mem_wdata); end
        s_data = 32'h12345678;   // held across DONE, then parsed as a header
        step();
        exp_hold[2] = 1'b0;
        total++; if ({core_hold, err} !== {exp_hold, 1'b0}) begin bad++; $display("FAIL trail_done: got hold=%h err=%b want %h 0", core_hold, err, exp_hold); end
        step();
        s_valid = 1'b0;
        total++; if ({err, busy, mem_we} !== 3'b100) begin bad++; $display("FAIL trail_as_hdr: got %b want 100", {err, busy, mem_we}); end
    endtask
`endif

    task automatic test_reset_midload();
        s_valid = 1'b1; s_data = 32'hA5000503;
        step();
        s_data = 32'hAAAA0000; step();
        s_data = 32'hAAAA0001; step();
        total++; if ({busy, core_hold[3]} !== 2'b11) begin bad++; $display("FAIL midload_busy: got %b want 11", {busy, core_hold[3]}); end
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_hold = '1;
        total++; if ({core_hold, busy, err, mem_we} !== {exp_hold, 3'b000}) begin bad++; $display("FAIL midload_reset: got hold=%h busy=%b err=%b we=%b", core_hold, busy, err, mem_we); end
        step();
        rst_n = 1'b1;
        step();
        s_valid = 1'b1; s_data = 32'h5A000000;
        step();
        s_valid = 1'b0;
        exp_hold[0] = 1'b0;
        total++; if ({core_hold, busy, err} !== {exp_hold, 2'b00}) begin bad++; $display("FAIL midload_fresh: got hold=%h busy=%b err=%b want %h 0 0", core_hold, busy, err, exp_hold); end
    endtask

    task automatic test_back_to_back_random();
        int k;
        int cyc;
        logic v;
        logic [31:0] cs;
        k = 0; cyc = 0; cs = '0;
        s_valid = 1'b1; s_data = 32'hA5008005;
        step();
        exp_hold[5] = 1'b1;
        total++; if (core_hold !== exp_hold) begin bad++; $display("FAIL rnd_hdr_hold: got %h want %h", core_hold, exp_hold); end
        cap_node.delete(); cap_addr.delete(); cap_data.delete();
        cap_en = 1'b1;
        while (k < 128 && cyc < 2000) begin
            v = 1'($urandom_range(0, 1));
            s_valid = v;
            s_data  = v ? (32'hC0DE0000 + 32'(k)) : $urandom;
            step();
            cyc++;
            if (v) begin
                cs = cs ^ (32'hC0DE0000 + 32'(k));
                k++;
            end
        end
        total++; if (k !== 128) begin bad++; $display("FAIL rnd_timeout: sent %0d want 128", k); end
`ifdef LOADER_CHECKSUM_EN
        s_valid = 1'b1; s_data = cs;
        step();
`endif
        s_valid = 1'b0;
        step();
        step();
        cap_en = 1'b0;
        exp_hold[5] = 1'b0;
        total++; if ({core_hold, busy, err} !== {exp_hold, 2'b00}) begin bad++; $display("FAIL rnd_end: got hold=%h busy=%b err=%b want %h 0 0", core_hold, busy, err, exp_hold); end
        total++; if (cap_addr.size() !== 128) begin bad++; $display("FAIL rnd_count: got %0d want 128", cap_addr.size()); end
        for (int i = 0; i < cap_addr.size() && i < 128; i++) begin
            total++; if ({cap_node[i], cap_addr[i], cap_data[i]} !== {4'd5, 7'(i), 32'hC0DE0000 + 32'(i)}) begin bad++; $display("FAIL rnd_write%0d: got n=%h a=%h d=%h", i, cap_node[i], cap_addr[i], cap_data[i]); end
        end
    endtask

    initial begin
        exp_hold = '1;
        test_reset();
        test_load_basic();
        test_release();
        test_bad_headers();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`else
        test_trailing_word();
`endif
        test_reset_midload();
        test_back_to_back_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
